// File: rtl/canny_pkg.sv
// Shared definitions for the Canny streaming pipeline stages.
// Holds the default pixel width and the window generator state encoding.
package canny_pkg;

  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } win_state_t;

endpackage

// File: rtl/line_buffer.sv
// WIDTH-deep delay line: o_data is the sample written WIDTH advances ago.
// Read-before-write on a single pointer; storage is not reset so it maps to RAM.
module line_buffer #(
  parameter int WIDTH      = 640,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_adv,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(WIDTH - 1);

  logic [DATA_WIDTH-1:0] r_mem [WIDTH];
  logic [AW-1:0]         r_ptr;

  assign o_data = r_mem[r_ptr];

  always_ff @(posedge i_clk) begin
    if (i_adv) r_mem[r_ptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)      r_ptr <= '0;
    else if (i_adv) r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
  end

endmodule

// File: rtl/window3x3_gen.sv
// Streaming 3x3 window generator: two line buffers plus three 3-tap rows,
// zero-filled borders, internal flush of the final line at frame end.
module window3x3_gen
  import canny_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WIDTH      = 640,
  parameter int DEPTH      = 504
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pix_en,
  input  logic [DATA_WIDTH-1:0] pix_in,
  output logic                  in_ready,
  output logic                  matrix_clken,
  output logic                  data_valid,
  output logic [DATA_WIDTH-1:0] matrix_p11,
  output logic [DATA_WIDTH-1:0] matrix_p12,
  output logic [DATA_WIDTH-1:0] matrix_p13,
  output logic [DATA_WIDTH-1:0] matrix_p21,
  output logic [DATA_WIDTH-1:0] matrix_p22,
  output logic [DATA_WIDTH-1:0] matrix_p23,
  output logic [DATA_WIDTH-1:0] matrix_p31,
  output logic [DATA_WIDTH-1:0] matrix_p32,
  output logic [DATA_WIDTH-1:0] matrix_p33,
  output logic                  frame_done,
  output win_state_t            dbg_state
);

  // Handshake: a pixel is taken on a rising edge where pix_en=1 and in_ready=1;
  // in_ready is high only in RUN and there is no backpressure inside the block.

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(DEPTH);
  localparam int FW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(DEPTH - 1);
  localparam logic [FW-1:0] FL_LAST  = FW'(WIDTH);

  win_state_t            r_state, w_next;
  logic [CW-1:0]         r_in_col, r_out_col;
  logic [RW-1:0]         r_in_row, r_out_row;
  logic [FW-1:0]         r_fl_cnt;
  logic                  w_adv, w_emit, w_ready;
  logic [DATA_WIDTH-1:0] w_in, w_lb1, w_lb2;
  logic [DATA_WIDTH-1:0] r_r1a, r_r1b, r_r2a, r_r2b, r_r3a, r_r3b;
  logic                  w_top, w_bot, w_left, w_right;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_adv   = 1'b0;
    w_emit  = 1'b0;
    w_in    = '0;
    case (r_state)
      IDLE: if (start) w_next = RUN;
      RUN: begin
        w_ready = 1'b1;
        w_adv   = pix_en;
        w_in    = pix_in;
        // Centre trails the input by WIDTH+1, so nothing emits before index WIDTH+1.
        w_emit  = pix_en && ((r_in_row >= RW'(2)) ||
                             ((r_in_row == RW'(1)) && (r_in_col != '0)));
        if (pix_en && (r_in_row == ROW_LAST) && (r_in_col == COL_LAST)) w_next = FLUSH;
      end
      FLUSH: begin
        w_adv  = 1'b1;
        w_emit = 1'b1;
        if (r_fl_cnt == FL_LAST) w_next = RUN;
      end
      default: w_next = IDLE;
    endcase
    if (!start) begin
      w_next = IDLE;
      w_adv  = 1'b0;
      w_emit = 1'b0;
    end
  end

  assign in_ready  = w_ready;
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst || !start) begin
      r_in_col  <= '0;
      r_in_row  <= '0;
      r_out_col <= '0;
      r_out_row <= '0;
      r_fl_cnt  <= '0;
    end else begin
      if ((r_state == RUN) && w_adv) begin
        r_in_col <= (r_in_col == COL_LAST) ? '0 : r_in_col + 1'b1;
        if (r_in_col == COL_LAST) r_in_row <= (r_in_row == ROW_LAST) ? '0 : r_in_row + 1'b1;
      end
      if (r_state == FLUSH) r_fl_cnt <= (r_fl_cnt == FL_LAST) ? '0 : r_fl_cnt + 1'b1;
      else                  r_fl_cnt <= '0;
      if (w_emit) begin
        r_out_col <= (r_out_col == COL_LAST) ? '0 : r_out_col + 1'b1;
        if (r_out_col == COL_LAST) r_out_row <= (r_out_row == ROW_LAST) ? '0 : r_out_row + 1'b1;
      end
    end
  end

  line_buffer #(.WIDTH(WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_lb1 (
    .i_clk(clk), .i_rst(rst), .i_adv(w_adv), .i_data(w_in), .o_data(w_lb1)
  );

  line_buffer #(.WIDTH(WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_lb2 (
    .i_clk(clk), .i_rst(rst), .i_adv(w_adv), .i_data(w_lb1), .o_data(w_lb2)
  );

  // Column 3 taps come straight from the chain; columns 2 and 1 are one and two advances older.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_r1a <= w_lb2;
      r_r1b <= r_r1a;
      r_r2a <= w_lb1;
      r_r2b <= r_r2a;
      r_r3a <= w_in;
      r_r3b <= r_r3a;
    end
  end

  assign w_top   = (r_out_row == '0);
  assign w_bot   = (r_out_row == ROW_LAST);
  assign w_left  = (r_out_col == '0);
  assign w_right = (r_out_col == COL_LAST);

  always_ff @(posedge clk) begin
    if (rst || !w_emit) begin
      matrix_clken <= 1'b0;
      data_valid   <= 1'b0;
      frame_done   <= 1'b0;
      matrix_p11   <= '0;
      matrix_p12   <= '0;
      matrix_p13   <= '0;
      matrix_p21   <= '0;
      matrix_p22   <= '0;
      matrix_p23   <= '0;
      matrix_p31   <= '0;
      matrix_p32   <= '0;
      matrix_p33   <= '0;
    end else begin
      matrix_clken <= 1'b1;
      data_valid   <= w_top | w_bot | w_left | w_right;
      frame_done   <= w_bot & w_right;
      // Right-column mask also hides the wrap into the next line's first pixels.
      matrix_p11   <= (w_top || w_left)  ? '0 : r_r1b;
      matrix_p12   <= w_top              ? '0 : r_r1a;
      matrix_p13   <= (w_top || w_right) ? '0 : w_lb2;
      matrix_p21   <= w_left             ? '0 : r_r2b;
      matrix_p22   <= r_r2a;
      matrix_p23   <= w_right            ? '0 : w_lb1;
      matrix_p31   <= (w_bot || w_left)  ? '0 : r_r3b;
      matrix_p32   <= w_bot              ? '0 : r_r3a;
      matrix_p33   <= (w_bot || w_right) ? '0 : w_in;
    end
  end

endmodule

// File: tb/tb_window3x3_gen.sv
// Directed bench for window3x3_gen at WIDTH=4, DEPTH=3 with a hand-built window table
// and an expected-window queue consumed cycle by cycle.
module tb_window3x3_gen;
  import canny_pkg::*;

  localparam int DW = 16;
  localparam int W  = 4;
  localparam int D  = 3;
  localparam int WW = 9 * DW + 2;

  // clock / reset
  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          start  = 1'b1;
  logic          pix_en = 1'b0;
  logic [DW-1:0] pix_in = '0;

  logic          in_ready, matrix_clken, data_valid, frame_done;
  logic [DW-1:0] matrix_p11, matrix_p12, matrix_p13;
  logic [DW-1:0] matrix_p21, matrix_p22, matrix_p23;
  logic [DW-1:0] matrix_p31, matrix_p32, matrix_p33;
  win_state_t    dbg_state;

  always #5 clk = ~clk;

  window3x3_gen #(.DATA_WIDTH(DW), .WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_en(pix_en), .pix_in(pix_in),
    .in_ready(in_ready), .matrix_clken(matrix_clken), .data_valid(data_valid),
    .matrix_p11(matrix_p11), .matrix_p12(matrix_p12), .matrix_p13(matrix_p13),
    .matrix_p21(matrix_p21), .matrix_p22(matrix_p22), .matrix_p23(matrix_p23),
    .matrix_p31(matrix_p31), .matrix_p32(matrix_p32), .matrix_p33(matrix_p33),
    .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [WW-1:0] exp_q[$];
  int win_seen = 0;
  int interior = 0;

  // Taps p11..p33 per centre in raster order; entries are pixel numbers, 0 = zero-filled.
  int tab [12][9] = '{
    '{0, 0, 0,  0, 1, 2,   0, 5, 6},
    '{0, 0, 0,  1, 2, 3,   5, 6, 7},
    '{0, 0, 0,  2, 3, 4,   6, 7, 8},
    '{0, 0, 0,  3, 4, 0,   7, 8, 0},
    '{0, 1, 2,  0, 5, 6,   0, 9, 10},
    '{1, 2, 3,  5, 6, 7,   9, 10, 11},
    '{2, 3, 4,  6, 7, 8,   10, 11, 12},
    '{3, 4, 0,  7, 8, 0,   11, 12, 0},
    '{0, 5, 6,  0, 9, 10,  0, 0, 0},
    '{5, 6, 7,  9, 10, 11, 0, 0, 0},
    '{6, 7, 8,  10, 11, 12, 0, 0, 0},
    '{7, 8, 0,  11, 12, 0, 0, 0, 0}
  };

  // bench model of acceptance: 0 idle, 1 run, 2 flush
  int m_state = 0;
  int m_idx   = 0;
  int m_fcnt  = 0;

  logic [WW-1:0] w_obs;
  assign w_obs = {frame_done, data_valid,
                  matrix_p11, matrix_p12, matrix_p13,
                  matrix_p21, matrix_p22, matrix_p23,
                  matrix_p31, matrix_p32, matrix_p33};

  task automatic check_val(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] pack_win(input int k, input int off);
    logic [WW-1:0] w;
    w = '0;
    for (int j = 0; j < 9; j++)
      w[(8-j)*DW +: DW] = (tab[k][j] == 0) ? '0 : DW'(tab[k][j] + off);
    w[WW-2] = !(k == 5 || k == 6);
    w[WW-1] = (k == 11);
    return w;
  endfunction

  // driver tasks
  task automatic load_frame(input int off);
    for (int k = 0; k < 12; k++) exp_q.push_back(pack_win(k, off));
  endtask

  task automatic cycle(input bit en, input logic [DW-1:0] val);
    bit acc, fl, emit;
    logic [WW-1:0] exp;
    pix_en = en;
    pix_in = val;
    check_val("in_ready", WW'(in_ready), WW'(m_state == 1));
    acc  = (m_state == 1) && en && start && !rst;
    fl   = (m_state == 2) && start && !rst;
    emit = fl || (acc && (m_idx >= W + 1));
    @(posedge clk);
    #1;
    if (rst || !start) begin
      m_state = 0; m_idx = 0; m_fcnt = 0;
    end else begin
      case (m_state)
        0: m_state = 1;
        1: if (acc) begin
             if (m_idx == W*D - 1) begin m_state = 2; m_idx = 0; m_fcnt = 0; end
             else m_idx++;
           end
        default: begin
          if (m_fcnt == W) begin m_state = 1; m_fcnt = 0; end
          else m_fcnt++;
        end
      endcase
    end
    check_val("clken", WW'(matrix_clken), WW'(emit));
    if (emit) begin
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      check_val("window", w_obs, exp);
    end else begin
      check_val("idle_zero", w_obs, '0);
    end
    if (matrix_clken) begin
      win_seen++;
      if (!data_valid) interior++;
    end
  endtask

  task automatic send_frame(input int off, input bit gap);
    load_frame(off);
    win_seen = 0;
    interior = 0;
    for (int i = 0; i < W*D; i++) begin
      if (gap) cycle(1'b0, '0);
      cycle(1'b1, DW'(i + 1 + off));
    end
    // in_ready must stay low through the flush, so these 99s are never taken
    for (int f = 0; f < W + 1; f++) cycle(1'b1, DW'(99));
    check_val("frame_done", WW'(frame_done), WW'(1));
    check_val("ready_at_done", WW'(in_ready), WW'(1));
    check_val("win_count", WW'(win_seen), WW'(W*D));
    check_val("interior_cnt", WW'(interior), WW'(2));
    check_val("queue_empty", WW'(exp_q.size()), WW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    check_val("reset_state", WW'(dbg_state), WW'(IDLE));
    rst = 1'b0;
    cycle(1'b0, '0);
    check_val("run_state", WW'(dbg_state), WW'(RUN));

    send_frame(0, 1'b0);
    send_frame(100, 1'b0);
    send_frame(0, 1'b1);

    // abort mid-frame, then replay
    load_frame(0);
    for (int i = 0; i < 7; i++) cycle(1'b1, DW'(i + 1));
    start = 1'b0;
    cycle(1'b1, DW'(8));
    exp_q.delete();
    cycle(1'b0, '0);
    check_val("abort_state", WW'(dbg_state), WW'(IDLE));
    start = 1'b1;
    cycle(1'b0, '0);
    send_frame(0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
